wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameter DEPTH, 16, number of trace entries; power of two, 2..256.
REQ-002 Parameter CNTW, $clog2(DEPTH)+1, width of Count.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 PCAddResult  input  32  CPU PC+4 value, sampled every cycle.
REQ-006 WriteData  input  32  CPU write-back data, sampled with PCAddResult.
REQ-007 CapEn  input  1  capture enable; no pushes while 0.
REQ-008 Clear  input  1  synchronous flush of buffer and status.
REQ-009 RdReady  input  1  host consumer ready.
REQ-010 RdValid  output  1  head entry available.
REQ-011 RdPC  output  32  PCAddResult of head entry.
REQ-012 RdData  output  32  WriteData of head entry.
REQ-013 Count  output  CNTW  number of stored entries, 0..DEPTH.
REQ-014 Overflow  output  1  sticky, set when a capture is dropped.
REQ-015 DropCount  output  8  saturating count of dropped captures.

Function
REQ-016 Buffer SHALL be a circular FIFO of DEPTH entries, each {PC[31:0], Data[31:0]}; write/read pointers wrap modulo DEPTH.
REQ-017 A capture request SHALL be raised in a cycle when CapEn=1 and the capture qualifier (REQ-031/032) is true.
REQ-018 Pop SHALL occur when RdValid=1 and RdReady=1 at a rising edge.
REQ-019 Push SHALL be accepted when capture requested and (Count<DEPTH or pop in the same cycle).
REQ-020 Full (Count=DEPTH) with capture request and no pop: entry dropped, buffer unchanged, Overflow set to 1, DropCount incremented, saturating at 255.
REQ-021 Empty with capture request: entry visible with RdValid=1 the following cycle; no same-cycle fall-through.
REQ-022 Simultaneous push and pop: Count unchanged, both pointers advance, head becomes next entry.
REQ-023 RdValid SHALL equal (Count!=0); RdPC/RdData SHALL present the entry at read pointer and remain stable while RdValid=1 and RdReady=0.
REQ-024 RdPC/RdData SHALL be 0 when Count=0.
REQ-025 Clear=1 SHALL, at the next edge, zero pointers, Count, Overflow, DropCount, and dedup register; Clear takes priority over push and pop in the same cycle.
REQ-026 Overflow SHALL remain 1 until Clear or Reset, regardless of later pops.

Reset
REQ-027 Reset low SHALL immediately force RdValid=0, RdPC=0, RdData=0, Count=0, Overflow=0, DropCount=0, pointers=0, dedup register=0.
REQ-028 Storage array contents need not be reset; stale data SHALL never be visible as RdValid=0 masks it.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; no pop or push SHALL complete in the reset-release cycle edge unless Reset was high before that edge.
REQ-030 First capture permitted on the first rising edge with Reset high.

Configuration
REQ-031 With macro WB_TRACE_DEDUP_EN defined: a register LastPC (updated every cycle with PCAddResult, reset 0) is kept and capture qualifier = (PCAddResult != LastPC), so stalled cycles repeating the same PC are not recorded.
REQ-032 Without WB_TRACE_DEDUP_EN: no LastPC register; capture qualifier = 1, every cycle with CapEn=1 is recorded.

Verification
REQ-033 Reset low 2 cycles, release, CapEn=1, PCAddResult 4,8,12 with WriteData 0xA,0xB,0xC, RdReady=0 -> Count=3, RdValid=1, RdPC=4, RdData=0xA.
REQ-034 After REQ-033 set RdReady=1 three cycles, CapEn=0 -> heads 4,8,12 popped in order, then Count=0, RdValid=0, RdPC=0.
REQ-035 DEPTH=16, RdReady=0, 20 distinct PCs captured -> Count=16, Overflow=1, DropCount=4; first pop returns the first captured PC.
REQ-036 Full buffer, RdReady=1 and new PC 0x100 same cycle -> Count stays 16, tail entry RdPC=0x100 appears after 15 further pops, DropCount unchanged.
REQ-037 WB_TRACE_DEDUP_EN defined, PCAddResult held at 0x20 for 5 cycles with CapEn=1 -> Count=1; undefined -> Count=5.
REQ-038 Count=5, Overflow=1, assert Clear with RdReady=1 and a capture request -> next cycle Count=0, Overflow=0, DropCount=0, RdValid=0.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Circular trace FIFO of {PC+4, write-back data} pairs with sticky overflow and drop counter.
// Optional macro WB_TRACE_DEDUP_EN suppresses captures that repeat the previous cycle's PC.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [31:0]     PCAddResult,
    input  logic [31:0]     WriteData,
    input  logic            CapEn,
    input  logic            Clear,
    input  logic            RdReady,
    output logic            RdValid,
    output logic [31:0]     RdPC,
    output logic [31:0]     RdData,
    output logic [CNTW-1:0] Count,
    output logic            Overflow,
    output logic [7:0]      DropCount
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            overflow;
    logic [7:0]      drop_cnt;
    logic            cap_qual, cap_req, full, pop, push, drop;

`ifdef WB_TRACE_DEDUP_EN
    logic [31:0] last_pc;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)     last_pc <= '0;
        else if (Clear) last_pc <= '0;
        else            last_pc <= PCAddResult;
    end

    assign cap_qual = (PCAddResult != last_pc);
`else
    assign cap_qual = 1'b1;
`endif

    assign full    = (count == CNTW'(DEPTH));
    assign pop     = (count != '0) && RdReady;
    assign cap_req = CapEn && cap_qual;
    // A pop in the same cycle frees the slot the push needs, so full does not block it.
    assign push    = cap_req && (!full || pop);
    assign drop    = cap_req && full && !pop;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (Clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Storage is not reset; an empty buffer masks whatever stale data it holds.
    always_ff @(posedge Clk) begin
        if (Reset && push && !Clear) mem[wr_ptr] <= '{pc: PCAddResult, data: WriteData};
    end

    assign head      = mem[rd_ptr];
    assign RdValid   = (count != '0);
    assign RdPC      = RdValid ? head.pc   : '0;
    assign RdData    = RdValid ? head.data : '0;
    assign Count     = count;
    assign Overflow  = overflow;
    assign DropCount = drop_cnt;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: a queue model tracks expected contents and status.
module tb_wb_trace_buffer;
    localparam int DEPTH = 16;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [31:0]     PCAddResult, WriteData;
    logic            CapEn, Clear, RdReady;
    logic            RdValid;
    logic [31:0]     RdPC, RdData;
    logic [CNTW-1:0] Count;
    logic            Overflow;
    logic [7:0]      DropCount;

    wb_trace_buffer #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .WriteData(WriteData),
        .CapEn(CapEn), .Clear(Clear), .RdReady(RdReady), .RdValid(RdValid),
        .RdPC(RdPC), .RdData(RdData), .Count(Count), .Overflow(Overflow),
        .DropCount(DropCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    bit          m_ovf;
    int          m_drop;
    logic [31:0] m_last;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out();
        chk("count", 64'(Count), 64'(q.size()));
        chk("rdvalid", 64'(RdValid), 64'(q.size() != 0));
        chk("rdpc", 64'(RdPC), (q.size() != 0) ? 64'(q[0].pc) : 64'd0);
        chk("rddata", 64'(RdData), (q.size() != 0) ? 64'(q[0].data) : 64'd0);
        chk("overflow", 64'(Overflow), 64'(m_ovf));
        chk("dropcount", 64'(DropCount), 64'(m_drop));
    endtask

    function automatic void model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        m_last = '0;
    endfunction

    // Check current outputs, advance the model by one edge with the driven inputs, take the edge.
    task automatic tick();
        bit   pop, cap, full;
        ent_t e;
        chk_out();
        pop  = (q.size() != 0) && RdReady;
        full = (q.size() == DEPTH);
        cap  = CapEn;
`ifdef WB_TRACE_DEDUP_EN
        cap  = cap && (PCAddResult != m_last);
`endif
        if (Clear) begin
            model_reset();
        end else begin
            if (pop) void'(q.pop_front());
            if (cap && (!full || pop)) begin
                e.pc   = PCAddResult;
                e.data = WriteData;
                q.push_back(e);
            end else if (cap) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            m_last = PCAddResult;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic set_in(input bit cap, input bit rdy, input logic [31:0] pc, input logic [31:0] dat);
        CapEn       = cap;
        RdReady     = rdy;
        PCAddResult = pc;
        WriteData   = dat;
    endtask

    task automatic cap_run(input int n, input logic [31:0] base, input bit rdy);
        for (int i = 0; i < n; i++) begin
            set_in(1'b1, rdy, base + 32'(4 * i), $urandom);
            tick();
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, rdy, 32'hFFFF_0000 + 32'(i), '0);
            tick();
        end
    endtask

    initial begin
        Reset = 1'b0;
        Clear = 1'b0;
        set_in(1'b0, 1'b0, '0, '0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk_out();
        Reset = 1'b1;

        // Three captures with consumer stalled, then drain in order.
        set_in(1'b1, 1'b0, 32'd4, 32'hA);  tick();
        set_in(1'b1, 1'b0, 32'd8, 32'hB);  tick();
        set_in(1'b1, 1'b0, 32'd12, 32'hC); tick();
        set_in(1'b0, 1'b0, 32'd12, 32'h0);
        chk("s1_count", 64'(Count), 64'd3);
        chk("s1_valid", 64'(RdValid), 64'd1);
        chk("s1_pc", 64'(RdPC), 64'd4);
        chk("s1_data", 64'(RdData), 64'hA);
        idle(2, 1'b0);
        chk("s1_hold", 64'(RdPC), 64'd4);
        idle(3, 1'b1);
        chk("s2_count", 64'(Count), 64'd0);
        chk("s2_valid", 64'(RdValid), 64'd0);
        chk("s2_pc", 64'(RdPC), 64'd0);

        // Overfill: 20 captures into 16 slots.
        cap_run(20, 32'h1000, 1'b0);
        chk("s3_count", 64'(Count), 64'd16);
        chk("s3_ovf", 64'(Overflow), 64'd1);
        chk("s3_drop", 64'(DropCount), 64'd4);
        chk("s3_head", 64'(RdPC), 64'h1000);

        // Push and pop together while full.
        set_in(1'b1, 1'b1, 32'h100, 32'h5A5A); tick();
        chk("s4_count", 64'(Count), 64'd16);
        chk("s4_drop", 64'(DropCount), 64'd4);
        idle(15, 1'b1);
        chk("s4_tail", 64'(RdPC), 64'h100);
        idle(1, 1'b1);
        chk("s4_ovf_sticky", 64'(Overflow), 64'd1);

        // Drop counter saturation.
        cap_run(16 + 260, 32'h2000, 1'b0);
        chk("s5_drop_sat", 64'(DropCount), 64'd255);

        // Clear, then a stalled PC repeated five cycles.
        Clear = 1'b1; idle(1, 1'b0); Clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, 32'h20, 32'(i)); tick();
        end
        set_in(1'b0, 1'b0, 32'h20, '0);
`ifdef WB_TRACE_DEDUP_EN
        chk("s6_dedup", 64'(Count), 64'd1);
`else
        chk("s6_dedup", 64'(Count), 64'd5);
`endif

        // Count=5 with overflow set, then Clear beats a simultaneous push and pop.
        Clear = 1'b1; idle(1, 1'b0); Clear = 1'b0;
        cap_run(18, 32'h3000, 1'b0);
        idle(11, 1'b1);
        chk("s7_count", 64'(Count), 64'd5);
        chk("s7_ovf", 64'(Overflow), 64'd1);
        Clear = 1'b1;
        set_in(1'b1, 1'b1, 32'h4444, 32'h1); tick();
        Clear = 1'b0;
        set_in(1'b0, 1'b0, 32'h4444, '0);
        chk("s7_clr_count", 64'(Count), 64'd0);
        chk("s7_clr_ovf", 64'(Overflow), 64'd0);
        chk("s7_clr_drop", 64'(DropCount), 64'd0);
        chk("s7_clr_valid", 64'(RdValid), 64'd0);

        // Asynchronous reset mid-transfer discards everything immediately.
        cap_run(6, 32'h5000, 1'b1);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        chk("s8_rst_valid", 64'(RdValid), 64'd0);
        chk("s8_rst_count", 64'(Count), 64'd0);
        chk("s8_rst_pc", 64'(RdPC), 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        set_in(1'b1, 1'b0, 32'h6000, 32'h77); tick();
        chk("s8_first_cap", 64'(RdPC), 64'h6000);

        // Random traffic with a small PC set so repeats occur.
        for (int i = 0; i < 300; i++) begin
            Clear = ($urandom_range(0, 49) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   32'(4 * $urandom_range(0, 3)), $urandom);
            tick();
        end
        Clear = 1'b0;
        idle(20, 1'b1);
        chk_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
